// File: rtl/game_controller_if.sv
// Signal bundle between the game controller and its surroundings.
// master drives the button/collision inputs; slave is the controller.
// Optional high-score output is present when GAME_CTRL_HISCORE_EN is defined.
interface game_controller_if;
  logic        btn_start;
  logic        btn_pause;
  logic        collision;
  logic        bar_pass;
  logic        tick_env;
  logic        pause;
  logic [9:0]  level;
  logic [13:0] score;
  logic [1:0]  state;
  logic        game_over;
`ifdef GAME_CTRL_HISCORE_EN
  logic [13:0] hiscore;

  modport master (
    output btn_start, btn_pause, collision, bar_pass,
    input  tick_env, pause, level, score, state, game_over, hiscore
  );

  modport slave (
    input  btn_start, btn_pause, collision, bar_pass,
    output tick_env, pause, level, score, state, game_over, hiscore
  );
`else
  modport master (
    output btn_start, btn_pause, collision, bar_pass,
    input  tick_env, pause, level, score, state, game_over
  );

  modport slave (
    input  btn_start, btn_pause, collision, bar_pass,
    output tick_env, pause, level, score, state, game_over
  );
`endif
endinterface

// File: rtl/game_controller.sv
// Game controller: IDLE/PLAY/PAUSE/OVER sequencing, environment step
// divider, score and level tracking. Every output comes from a register.
// Optional feature macro: GAME_CTRL_HISCORE_EN adds a high-score register
// that captures the final score of a game when it beats the previous best.
module game_controller #(
  parameter int TICK_DIV      = 2000000,
  parameter int PTS_PER_LEVEL = 10,
  parameter int MAX_LEVEL     = 99
) (
  input  logic             clk,
  input  logic             rst_n,
  game_controller_if.slave gc
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int PTS_W  = (PTS_PER_LEVEL > 1) ? $clog2(PTS_PER_LEVEL) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [PTS_W-1:0]  PTS_LAST  = PTS_W'(PTS_PER_LEVEL - 1);
  localparam logic [PTS_W-1:0]  PTS_ONE   = PTS_W'(1);
  localparam logic [13:0]       SCORE_MAX = 14'd9999;
  localparam logic [9:0]        LEVEL_MAX = 10'(MAX_LEVEL);

  // Score never wraps past the four-digit display range.
  function automatic logic [13:0] sat_inc_score(input logic [13:0] v);
    return (v >= SCORE_MAX) ? SCORE_MAX : v + 14'd1;
  endfunction

  // Level stops at the configured ceiling.
  function automatic logic [9:0] sat_inc_level(input logic [9:0] v);
    return (v >= LEVEL_MAX) ? LEVEL_MAX : v + 10'd1;
  endfunction

  logic [1:0]        state_q;
  logic [1:0]        state_nxt;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick_q;
  logic [PTS_W-1:0]  pts_cnt;
  logic [13:0]       score_q;
  logic [9:0]        level_q;
  logic              pause_q;
  logic              game_over_q;

  // A simultaneous start press wins over pause, so pause only counts alone.
  logic pause_ev;
  logic start_game;
  logic play_stay;
  logic bar_ev;
  logic over_ev;

  assign pause_ev   = gc.btn_pause & ~gc.btn_start;
  assign start_game = (state_q == ST_IDLE) & gc.btn_start;
  assign play_stay  = (state_q == ST_PLAY) & (state_nxt == ST_PLAY);
  assign bar_ev     = (state_q == ST_PLAY) & gc.bar_pass & ~gc.collision;
  assign over_ev    = (state_q == ST_PLAY) & gc.collision;

  // Next-state decode; collision outranks pause while playing.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:  if (gc.btn_start) state_nxt = ST_PLAY;
      ST_PLAY: begin
        if (gc.collision)   state_nxt = ST_OVER;
        else if (pause_ev)  state_nxt = ST_PAUSE;
      end
      ST_PAUSE: if (pause_ev) state_nxt = ST_PLAY;
      ST_OVER:  if (gc.btn_start) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register with pause/game_over decoded from the next state so they
  // line up with the registered state output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pause_q     <= 1'b1;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      pause_q     <= (state_nxt != ST_PLAY);
      game_over_q <= (state_nxt == ST_OVER);
    end
  end

  // Environment step divider; runs only on cycles that stay in PLAY so the
  // count is frozen across a pause and no step leaks out on the exit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      tick_q   <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (start_game) begin
        tick_cnt <= '0;
      end else if (play_stay) begin
        if (tick_cnt == TICK_LAST) begin
          tick_cnt <= '0;
          tick_q   <= 1'b1;
        end else begin
          tick_cnt <= tick_cnt + TICK_ONE;
        end
      end
    end
  end

  // Score and level bookkeeping; the point counter keeps wrapping even once
  // the level has hit its ceiling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q <= '0;
      level_q <= 10'd1;
      pts_cnt <= '0;
    end else if (start_game) begin
      score_q <= '0;
      level_q <= 10'd1;
      pts_cnt <= '0;
    end else if (bar_ev) begin
      score_q <= sat_inc_score(score_q);
      if (pts_cnt == PTS_LAST) begin
        pts_cnt <= '0;
        level_q <= sat_inc_level(level_q);
      end else begin
        pts_cnt <= pts_cnt + PTS_ONE;
      end
    end
  end

`ifdef GAME_CTRL_HISCORE_EN
  logic [13:0] hiscore_q;

  // Best score is taken at the moment a game ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hiscore_q <= '0;
    end else if (over_ev && (score_q > hiscore_q)) begin
      hiscore_q <= score_q;
    end
  end

  assign gc.hiscore = hiscore_q;
`else
  logic unused_over;
  assign unused_over = over_ev;
`endif

  assign gc.state     = state_q;
  assign gc.pause     = pause_q;
  assign gc.game_over = game_over_q;
  assign gc.tick_env  = tick_q;
  assign gc.score     = score_q;
  assign gc.level     = level_q;

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller: two instances (level ceilings 99 and 2)
// share the same stimulus; a rule-level model predicts each cycle's outputs.
module tb_game_controller;
  localparam int TDIV = 4;
  localparam int PTS  = 3;
  localparam int MAXA = 99;
  localparam int MAXB = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  game_controller_if ifa ();
  game_controller_if ifb ();

  game_controller #(.TICK_DIV(TDIV), .PTS_PER_LEVEL(PTS), .MAX_LEVEL(MAXA))
    dut_a (.clk(clk), .rst_n(rst_n), .gc(ifa.slave));
  game_controller #(.TICK_DIV(TDIV), .PTS_PER_LEVEL(PTS), .MAX_LEVEL(MAXB))
    dut_b (.clk(clk), .rst_n(rst_n), .gc(ifb.slave));

  typedef struct {
    int st;
    int score;
    int level;
    int tcnt;
    int pts;
    int hi;
    int tick;
  } mdl_t;

  typedef struct {
    mdl_t a;
    mdl_t b;
  } exp_t;

  exp_t sbq[$];
  mdl_t ma, mb;
  int checks = 0;
  int errors = 0;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.st = 0; m.score = 0; m.level = 1; m.tcnt = 0; m.pts = 0; m.hi = 0; m.tick = 0;
    return m;
  endfunction

  // Game rules: 0 idle, 1 play, 2 pause, 3 over.
  function automatic mdl_t step(mdl_t m, bit s, bit p, bit c, bit b, int maxl);
    mdl_t n = m;
    bit pz = p && !s;
    n.tick = 0;
    if (m.st == 0) begin
      if (s) begin
        n.st = 1; n.score = 0; n.level = 1; n.pts = 0; n.tcnt = 0;
      end
    end else if (m.st == 1) begin
      if (c) begin
        n.st = 3;
        if (m.score > m.hi) n.hi = m.score;
      end else begin
        if (b) begin
          n.score = (m.score + 1 > 9999) ? 9999 : m.score + 1;
          n.pts = m.pts + 1;
          if (n.pts == PTS) begin
            n.pts = 0;
            n.level = (m.level + 1 > maxl) ? maxl : m.level + 1;
          end
        end
        if (pz) n.st = 2;
        else begin
          n.tcnt = (m.tcnt + 1) % TDIV;
          if (n.tcnt == 0) n.tick = 1;
        end
      end
    end else if (m.st == 2) begin
      if (pz) n.st = 1;
    end else begin
      if (s) n.st = 0;
    end
    return n;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, got, want, $time);
    end
  endtask

  task automatic cmp(string tag, logic [1:0] st, logic pa, logic go, logic tk,
                     logic [9:0] lv, logic [13:0] sc, logic [13:0] hs, mdl_t m);
    chk({tag, "_state"}, 32'(st), 32'(m.st));
    chk({tag, "_pause"}, 32'(pa), (m.st != 1) ? 32'd1 : 32'd0);
    chk({tag, "_game_over"}, 32'(go), (m.st == 3) ? 32'd1 : 32'd0);
    chk({tag, "_tick_env"}, 32'(tk), 32'(m.tick));
    chk({tag, "_level"}, 32'(lv), 32'(m.level));
    chk({tag, "_score"}, 32'(sc), 32'(m.score));
`ifdef GAME_CTRL_HISCORE_EN
    chk({tag, "_hiscore"}, 32'(hs), 32'(m.hi));
`else
    if (hs != 14'd0) $display("note: unexpected hiscore arg");
`endif
  endtask

  function automatic logic [13:0] hs_a();
`ifdef GAME_CTRL_HISCORE_EN
    return ifa.hiscore;
`else
    return 14'd0;
`endif
  endfunction

  function automatic logic [13:0] hs_b();
`ifdef GAME_CTRL_HISCORE_EN
    return ifb.hiscore;
`else
    return 14'd0;
`endif
  endfunction

  // Monitor: outputs are valid every cycle, compare one edge after drive.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        cmp("a", ifa.state, ifa.pause, ifa.game_over, ifa.tick_env, ifa.level, ifa.score, hs_a(), e.a);
        cmp("b", ifb.state, ifb.pause, ifb.game_over, ifb.tick_env, ifb.level, ifb.score, hs_b(), e.b);
      end
    end
  end

  task automatic set_in(bit s, bit p, bit c, bit b);
    ifa.btn_start = s; ifa.btn_pause = p; ifa.collision = c; ifa.bar_pass = b;
    ifb.btn_start = s; ifb.btn_pause = p; ifb.collision = c; ifb.bar_pass = b;
  endtask

  task automatic drive(bit s, bit p, bit c, bit b);
    exp_t e;
    @(negedge clk);
    set_in(s, p, c, b);
    ma = step(ma, s, p, c, b, MAXA);
    mb = step(mb, s, p, c, b, MAXB);
    e.a = ma;
    e.b = mb;
    sbq.push_back(e);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
  endtask

  task automatic goto_play();
    for (int i = 0; i < 8 && ma.st != 1; i++) begin
      if (ma.st == 2) drive(0, 1, 0, 0);
      else drive(1, 0, 0, 0);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_values(string tag);
    chk({tag, "_state"}, 32'(ifa.state), 32'd0);
    chk({tag, "_pause"}, 32'(ifa.pause), 32'd1);
    chk({tag, "_tick_env"}, 32'(ifa.tick_env), 32'd0);
    chk({tag, "_level"}, 32'(ifa.level), 32'd1);
    chk({tag, "_score"}, 32'(ifa.score), 32'd0);
    chk({tag, "_game_over"}, 32'(ifa.game_over), 32'd0);
    chk({tag, "_b_level"}, 32'(ifb.level), 32'd1);
`ifdef GAME_CTRL_HISCORE_EN
    chk({tag, "_hiscore"}, 32'(ifa.hiscore), 32'd0);
`endif
  endtask

  initial begin : stim
    set_in(0, 0, 0, 0);
    ma = mdl_reset();
    mb = mdl_reset();
    #23;
    check_reset_values("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Start, then free-run to observe the step divider.
    drive(1, 0, 0, 0);
    idle(10);

    // Seven bars: score 7, level 3 (ceiling 2 on instance b).
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 0, 1);
      drive(0, 0, 0, 0);
    end
    after_edge();
    chk("bars7_score", 32'(ifa.score), 32'd7);
    chk("bars7_level_a", 32'(ifa.level), 32'd3);
    chk("bars7_level_b", 32'(ifb.level), 32'd2);

    // Fresh game, pause with the divider at 2, hold, resume.
    drive(0, 0, 1, 0);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    idle(2);
    drive(0, 1, 0, 0);
    idle(10);
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 0);
    after_edge();
    chk("resume_tick_early", 32'(ifa.tick_env), 32'd0);
    drive(0, 0, 0, 0);
    after_edge();
    chk("resume_tick_2nd", 32'(ifa.tick_env), 32'd1);

    // Collision and bar pass together at score 5.
    drive(0, 0, 1, 0);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 1);
    drive(0, 0, 1, 1);
    after_edge();
    chk("over_state", 32'(ifa.state), 32'd3);
    chk("over_flag", 32'(ifa.game_over), 32'd1);
    chk("over_score", 32'(ifa.score), 32'd5);
    drive(1, 0, 0, 0);
    after_edge();
    chk("ack_state", 32'(ifa.state), 32'd0);
    chk("idle_score_held", 32'(ifa.score), 32'd5);
    drive(1, 1, 0, 0);
    after_edge();
    chk("restart_state", 32'(ifa.state), 32'd1);
    chk("restart_score", 32'(ifa.score), 32'd0);
    chk("restart_level", 32'(ifa.level), 32'd1);

    // Two games scoring 6 then 4.
    drive(0, 0, 1, 0);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 1);
    drive(0, 0, 1, 0);
    drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1);
    drive(0, 0, 1, 0);
    after_edge();
`ifdef GAME_CTRL_HISCORE_EN
    chk("hiscore_6_4", 32'(ifa.hiscore), 32'd6);
`endif
    chk("game2_score", 32'(ifa.score), 32'd4);

    // Randomized play.
    for (int i = 0; i < 3000; i++) begin
      drive(bit'($urandom_range(0, 19) == 0), bit'($urandom_range(0, 24) == 0),
            bit'($urandom_range(0, 39) == 0), bit'($urandom_range(0, 2) == 0));
    end

    // Long uninterrupted run to hit the score and level ceilings.
    goto_play();
    for (int i = 0; i < 10010; i++) drive(0, 0, 0, 1);
    after_edge();
    chk("score_sat", 32'(ifa.score), 32'd9999);
    chk("level_sat", 32'(ifa.level), 32'd99);

    // Reset asynchronously in the middle of a game.
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 1);
    after_edge();
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_values("rst_mid");
    ma.st = 0;
    ma = mdl_reset();
    mb = mdl_reset();
    set_in(0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 1);
    drive(0, 1, 0, 0);
    drive(1, 0, 0, 0);
    for (int i = 0; i < 200; i++) begin
      drive(bit'($urandom_range(0, 19) == 0), bit'($urandom_range(0, 24) == 0),
            bit'($urandom_range(0, 39) == 0), bit'($urandom_range(0, 2) == 0));
    end
    idle(2);
    after_edge();
    after_edge();
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
